// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the MIPS pipeline control blocks.
// Holds the memory-wait FSM states, forwarding select codes and the zero-register match helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } memState_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $0 is hard-wired, so a hazard compare only counts against a real source register
    function automatic logic regMatch(input logic [4:0] src, input logic [4:0] dst);
        return (src != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm: tracks multi-cycle data-memory accesses and raises memHold while the pipeline must freeze.
// A sticky MemErr is set when an access stays unanswered for MEM_TIMEOUT cycles.
module mem_wait_fsm
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic CLK,
    input  logic Reset,
    input  logic MemReqM,
    input  logic MemReadyM,
    output logic memHold,
    output logic MemErr
);

    localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

    memState_e  state;
    memState_e  stateNext;
    logic [7:0] timer;
    logic [7:0] timerNext;
    logic [8:0] timerInc;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state  <= IDLE;
            timer  <= '0;
            MemErr <= 1'b0;
        end else begin
            state  <= stateNext;
            timer  <= timerNext;
            MemErr <= (stateNext == ERROR);
        end
    end

    // The timeout fires on the edge where the timer would reach MEM_TIMEOUT; a ready in that cycle wins.
    always_comb begin
        stateNext = state;
        timerNext = timer;
        memHold   = 1'b0;
        timerInc  = {1'b0, timer} + 9'd1;

        unique case (state)
            IDLE: begin
                if (MemReqM && !MemReadyM) begin
                    memHold   = 1'b1;
                    timerNext = 8'd1;
                    if (TIMEOUT_LIM <= 9'd1) begin
                        stateNext = ERROR;
                    end else begin
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                if (MemReadyM) begin
                    stateNext = IDLE;
                    timerNext = '0;
                end else begin
                    memHold   = MemReqM;
                    timerNext = timerInc[7:0];
                    if (timerInc >= TIMEOUT_LIM) begin
                        stateNext = ERROR;
                    end
                end
            end
            ERROR: begin
                memHold = 1'b1;
            end
            default: begin
                stateNext = IDLE;
                timerNext = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forwarding control for the 5-stage MIPS pipeline.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemToRegE,
    input  logic             MemToRegM,
    input  logic             BranchD,
    input  logic             JumpD,
    input  logic             PCSrcD,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    logic memHold;
    logic lwStall;
    logic brStall;
    logic hazStall;

    mem_wait_fsm #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) memWait (
        .CLK      (CLK),
        .Reset    (Reset),
        .MemReqM  (MemReqM),
        .MemReadyM(MemReadyM),
        .memHold  (memHold),
        .MemErr   (MemErr)
    );

    // The M-stage result is younger than W, so it wins when both target the same register.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (RegWriteM && regMatch(RsE, WriteRegM)) begin
            ForwardAE = FWD_M;
        end else if (RegWriteW && regMatch(RsE, WriteRegW)) begin
            ForwardAE = FWD_W;
        end
        if (RegWriteM && regMatch(RtE, WriteRegM)) begin
            ForwardBE = FWD_M;
        end else if (RegWriteW && regMatch(RtE, WriteRegW)) begin
            ForwardBE = FWD_W;
        end
    end

    assign ForwardAD = RegWriteM & regMatch(RsD, WriteRegM);
    assign ForwardBD = RegWriteM & regMatch(RtD, WriteRegM);

    assign lwStall = MemToRegE & (regMatch(RsD, RtE) | regMatch(RtD, RtE));

    // Branches resolve in D, so they must wait for an E-stage ALU result or an M-stage load.
    assign brStall = BranchD &
                     ((RegWriteE & (regMatch(RsD, WriteRegE) | regMatch(RtD, WriteRegE))) |
                      (MemToRegM & (regMatch(RsD, WriteRegM) | regMatch(RtD, WriteRegM))));

    assign hazStall = lwStall | brStall;

    // A frozen memory stage overrides everything: nothing advances and no bubbles are injected upstream.
    always_comb begin
        StallF = memHold | hazStall;
        StallD = memHold | hazStall;
        StallE = memHold;
        StallM = memHold;
        FlushW = memHold;
        FlushE = ~memHold & hazStall;
        FlushD = (PCSrcD | JumpD) & ~StallD & ~memHold;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCount;
    logic [CNT_W-1:0] flushCount;

    // Counters stop at all-ones rather than wrapping so long runs never report a small value.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (StallF && (stallCount != '1)) begin
                stallCount <= stallCount + CNT_W'(1);
            end
            if ((FlushE || FlushD) && (flushCount != '1)) begin
                flushCount <= flushCount + CNT_W'(1);
            end
        end
    end

    assign StallCnt = stallCount;
    assign FlushCnt = flushCount;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against an in-bench reference model.
// Expected counter values depend on whether HAZARD_PERF_CNT_EN is defined for the build.
module tb_hazard_unit;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic CLK = 1'b0;
    logic Reset;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM;
    logic BranchD, JumpD, PCSrcD, MemReqM, MemReadyM;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic ForwardAD, ForwardBD, MemErr;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCnt, FlushCnt;
    logic [12:0] dutVec;

    int errors = 0;
    int checks = 0;

    int     mPending = 0;
    bit     mErr = 1'b0;
    longint mStall = 0;
    longint mFlush = 0;

    always #5 CLK = ~CLK;

    hazard_unit #(
        .MEM_TIMEOUT(TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK(CLK), .Reset(Reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .MemToRegM(MemToRegM),
        .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    assign dutVec = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                     ForwardAD, ForwardBD, ForwardAE, ForwardBE};

    // Reference rules: a source register matches a destination only when it is not $0.
    function automatic bit hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwdSel(input logic [4:0] src);
        if (RegWriteM && hit(src, WriteRegM)) return 2'b10;
        if (RegWriteW && hit(src, WriteRegW)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [12:0] modelVec();
        bit lw, br, hold, hz, fd;
        lw = MemToRegE && (hit(RsD, RtE) || hit(RtD, RtE));
        br = BranchD && ((RegWriteE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE))) ||
                         (MemToRegM && (hit(RsD, WriteRegM) || hit(RtD, WriteRegM))));
        hold = mErr || (MemReqM && !MemReadyM);
        hz = lw || br;
        fd = (PCSrcD || JumpD) && !hold && !hz;
        if (hold)
            return {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                    RegWriteM && hit(RsD, WriteRegM), RegWriteM && hit(RtD, WriteRegM),
                    fwdSel(RsE), fwdSel(RtE)};
        return {hz, hz, 1'b0, 1'b0, fd, hz, 1'b0,
                RegWriteM && hit(RsD, WriteRegM), RegWriteM && hit(RtD, WriteRegM),
                fwdSel(RsE), fwdSel(RtE)};
    endfunction

    function automatic logic [CNT_W-1:0] expCnt(input longint v);
        return PERF ? CNT_W'(v) : '0;
    endfunction

    // Advance one clock, updating the model with the inputs the DUT samples on the same edge.
    task automatic tick();
        logic [12:0] v;
        @(posedge CLK);
        v = modelVec();
        if (Reset) begin
            mPending = 0;
            mErr     = 1'b0;
            mStall   = 0;
            mFlush   = 0;
        end else begin
            if (v[12]) mStall++;
            if (v[8] || v[7]) mFlush++;
            if (!mErr) begin
                if (mPending == 0) begin
                    if (MemReqM && !MemReadyM) mPending = 1;
                end else if (MemReadyM) begin
                    mPending = 0;
                end else begin
                    mPending++;
                end
                if (mPending >= TIMEOUT) mErr = 1'b1;
            end
        end
        #1;
    endtask

    task automatic setIdle();
        RsD = '0; RtD = '0; RsE = '0; RtE = '0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemToRegE = 0; MemToRegM = 0;
        BranchD = 0; JumpD = 0; PCSrcD = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic applyReset();
        Reset = 1'b1;
        setIdle();
        @(negedge CLK);
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        setIdle();
        repeat (2) begin
            @(negedge CLK);
            tick();
        end
        MemToRegE = 1; RtE = 5'd5; RsD = 5'd5;
        @(negedge CLK);
        checks++;
        if ({MemErr, StallCnt, FlushCnt} !== {1'b0, {CNT_W{1'b0}}, {CNT_W{1'b0}}}) begin
            errors++;
            $display("[TB] FAIL resetRegs: got err=%b stall=%0d flush=%0d want 0/0/0", MemErr, StallCnt, FlushCnt);
        end
        checks++;
        if ({StallF, StallM, FlushE} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL resetComb: got F/M/E=%b want 101", {StallF, StallM, FlushE});
        end
        tick();
        Reset = 1'b0;
        setIdle();
    endtask

    task automatic test_forwarding();
        setIdle();
        RsE = 5'd3; WriteRegM = 5'd3; RegWriteM = 1; WriteRegW = 5'd3; RegWriteW = 1;
        RtE = 5'd7; RsD = 5'd3;
        @(negedge CLK);
        checks++;
        if ({ForwardAE, ForwardAD} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL fwdM: got AE=%b AD=%b want 10/1", ForwardAE, ForwardAD);
        end
        tick();
        RegWriteM = 0; WriteRegW = 5'd3;
        @(negedge CLK);
        checks++;
        if ({ForwardAE, ForwardAD} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL fwdW: got AE=%b AD=%b want 01/0", ForwardAE, ForwardAD);
        end
        tick();
        RsE = 5'd0; WriteRegM = 5'd0; RegWriteM = 1; WriteRegW = 5'd0;
        RtE = 5'd7; RtD = 5'd0;
        @(negedge CLK);
        checks++;
        if ({ForwardAE, ForwardBE, ForwardBD} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL fwdZero: got AE=%b BE=%b BD=%b want 00/00/0", ForwardAE, ForwardBE, ForwardBD);
        end
        tick();
        RtE = 5'd7; WriteRegW = 5'd7; RegWriteW = 1; WriteRegM = 5'd3; RegWriteM = 1;
        @(negedge CLK);
        checks++;
        if (ForwardBE !== 2'b01) begin
            errors++;
            $display("[TB] FAIL fwdBE: got %b want 01", ForwardBE);
        end
        tick();
    endtask

    task automatic test_load_use();
        setIdle();
        MemToRegE = 1; RtE = 5'd5; RsD = 5'd5;
        @(negedge CLK);
        checks++;
        if ({StallF, StallD, FlushE, StallE} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL loadUse: got F/D/FE/E=%b want 1110", {StallF, StallD, FlushE, StallE});
        end
        tick();
        RsD = 5'd6; RtD = 5'd7;
        @(negedge CLK);
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL loadNoUse: got F/D/FE=%b want 000", {StallF, StallD, FlushE});
        end
        tick();
    endtask

    task automatic test_branch();
        setIdle();
        BranchD = 1; RsD = 5'd4; RegWriteE = 1; WriteRegE = 5'd4;
        @(negedge CLK);
        checks++;
        if ({StallD, FlushE} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL brAlu: got D/FE=%b want 11", {StallD, FlushE});
        end
        tick();
        RegWriteE = 0; MemToRegM = 1; WriteRegM = 5'd4;
        @(negedge CLK);
        checks++;
        if ({StallD, FlushE} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL brLoad: got D/FE=%b want 11", {StallD, FlushE});
        end
        tick();
        MemToRegM = 0; RegWriteM = 1; WriteRegM = 5'd9;
        @(negedge CLK);
        checks++;
        if ({ForwardAD, StallD, FlushE} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL brClear: got AD/D/FE=%b want 000", {ForwardAD, StallD, FlushE});
        end
        tick();
    endtask

    task automatic test_mem_wait();
        int holdCycles;
        setIdle();
        holdCycles = 0;
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                MemToRegE = 1; RtE = 5'd5; RsD = 5'd5;
            end else begin
                MemToRegE = 0;
            end
            @(negedge CLK);
            if (StallM && FlushW) holdCycles++;
            if (i == 1) begin
                checks++;
                if ({StallF, FlushE} !== 2'b10) begin
                    errors++;
                    $display("[TB] FAIL holdOverLw: got F/FE=%b want 10", {StallF, FlushE});
                end
            end
            tick();
        end
        MemToRegE = 0; MemReadyM = 1;
        @(negedge CLK);
        if (StallM || FlushW) holdCycles++;
        tick();
        MemReqM = 1; MemReadyM = 1;
        @(negedge CLK);
        if (StallF || StallM) holdCycles++;
        checks++;
        if (holdCycles !== 3) begin
            errors++;
            $display("[TB] FAIL waitLen: got %0d hold cycles want 3", holdCycles);
        end
        tick();
        MemReqM = 0;
        @(negedge CLK);
        checks++;
        if ({StallM, MemErr} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL waitIdle: got M/err=%b want 00", {StallM, MemErr});
        end
        tick();
    endtask

    task automatic test_timeout();
        setIdle();
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge CLK);
            checks++;
            if ({MemErr, StallM} !== 2'b01) begin
                errors++;
                $display("[TB] FAIL preTimeout%0d: got err/M=%b want 01", i, {MemErr, StallM});
            end
            tick();
        end
        @(negedge CLK);
        checks++;
        if ({MemErr, StallF, StallM} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL timeout: got err/F/M=%b want 111", {MemErr, StallF, StallM});
        end
        tick();
        MemReqM = 0; MemReadyM = 1;
        @(negedge CLK);
        checks++;
        if ({MemErr, StallM} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL errSticky: got err/M=%b want 11", {MemErr, StallM});
        end
        tick();
        applyReset();
        MemReqM = 0; MemReadyM = 0;
        @(negedge CLK);
        checks++;
        if ({MemErr, StallM} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL errReset: got err/M=%b want 00", {MemErr, StallM});
        end
        tick();
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            MemReadyM = (i == TIMEOUT - 1);
            @(negedge CLK);
            tick();
        end
        MemReqM = 0; MemReadyM = 0;
        @(negedge CLK);
        checks++;
        if ({MemErr, StallM} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL readyAtTimeout: got err/M=%b want 00", {MemErr, StallM});
        end
        tick();
        MemReqM = 1; MemReadyM = 0;
        repeat (2) begin
            @(negedge CLK);
            tick();
        end
        Reset = 1'b1;
        @(negedge CLK);
        tick();
        Reset = 1'b0;
        repeat (TIMEOUT - 1) begin
            @(negedge CLK);
            tick();
        end
        MemReadyM = 1;
        @(negedge CLK);
        checks++;
        if ({MemErr, StallM} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL midWaitReset: got err/M=%b want 00", {MemErr, StallM});
        end
        tick();
    endtask

    task automatic test_redirect_counters();
        applyReset();
        setIdle();
        PCSrcD = 1;
        @(negedge CLK);
        checks++;
        if (FlushD !== 1'b1) begin
            errors++;
            $display("[TB] FAIL redirect: got FlushD=%b want 1", FlushD);
        end
        tick();
        PCSrcD = 0; MemToRegE = 1; RtE = 5'd5; RsD = 5'd5;
        for (int i = 0; i < 3; i++) begin
            JumpD = (i == 0);
            @(negedge CLK);
            if (i == 0) begin
                checks++;
                if (FlushD !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL redirectStalled: got FlushD=%b want 0", FlushD);
                end
            end
            tick();
        end
        setIdle();
        @(negedge CLK);
        checks++;
        if (StallCnt !== (PERF ? CNT_W'(3) : CNT_W'(0))) begin
            errors++;
            $display("[TB] FAIL stallCnt: got %0d want %0d", StallCnt, PERF ? 3 : 0);
        end
        checks++;
        if (FlushCnt !== (PERF ? CNT_W'(4) : CNT_W'(0))) begin
            errors++;
            $display("[TB] FAIL flushCnt: got %0d want %0d", FlushCnt, PERF ? 4 : 0);
        end
        tick();
    endtask

    task automatic test_random();
        applyReset();
        for (int n = 0; n < 400; n++) begin
            Reset     = ($urandom_range(0, 63) == 0);
            RsD       = 5'($urandom_range(0, 7));
            RtD       = 5'($urandom_range(0, 7));
            RsE       = 5'($urandom_range(0, 7));
            RtE       = 5'($urandom_range(0, 7));
            WriteRegE = 5'($urandom_range(0, 7));
            WriteRegM = 5'($urandom_range(0, 7));
            WriteRegW = 5'($urandom_range(0, 7));
            RegWriteE = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemToRegE = 1'($urandom_range(0, 1));
            MemToRegM = 1'($urandom_range(0, 1));
            BranchD   = 1'($urandom_range(0, 1));
            JumpD     = ($urandom_range(0, 3) == 0);
            PCSrcD    = ($urandom_range(0, 3) == 0);
            MemReqM   = 1'($urandom_range(0, 1));
            MemReadyM = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            checks++;
            if (dutVec !== modelVec()) begin
                errors++;
                $display("[TB] FAIL randVec%0d: got %b want %b", n, dutVec, modelVec());
            end
            checks++;
            if ({MemErr, StallCnt, FlushCnt} !== {mErr, expCnt(mStall), expCnt(mFlush)}) begin
                errors++;
                $display("[TB] FAIL randRegs%0d: got err=%b s=%0d f=%0d want err=%b s=%0d f=%0d",
                         n, MemErr, StallCnt, FlushCnt, mErr, expCnt(mStall), expCnt(mFlush));
            end
            tick();
        end
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        setIdle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_redirect_counters();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
